// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-ported, byte-addressed data memory between two masters.
// Port 0 is the pipeline MEM stage and port 1 is a secondary master such as a
// loader or debug port. Each access uses a req/ack handshake. Ties are broken
// round-robin. Every access runs as one IDLE -> SERVE -> IDLE pass.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req*_i, we*_i               request level, write(1)/read(0)
//   addr*_i, wdata*_i           byte address and write data, stable until ack
//   ack*_o                      one-cycle completion pulse
//   rdata*_o                    read data, held until the next read on that port
//   stall0_o                    pipeline stall, equal to req0 & ~ack0
//   err_o                       pulses with ack for a misaligned/out-of-range access
//   busy_o                      high while an access is being served
//   mem_we_o, mem_re_o,
//   mem_addr_o, mem_wdata_o     memory control, all zero in IDLE
//   mem_rdata_i                 memory read data (combinational read)
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_i,
  input  logic                 we0_i,
  input  logic [WORD_SIZE-1:0] addr0_i,
  input  logic [WORD_SIZE-1:0] wdata0_i,
  output logic                 ack0_o,
  output logic [WORD_SIZE-1:0] rdata0_o,
  output logic                 stall0_o,
  input  logic                 req1_i,
  input  logic                 we1_i,
  input  logic [WORD_SIZE-1:0] addr1_i,
  input  logic [WORD_SIZE-1:0] wdata1_i,
  output logic                 ack1_o,
  output logic [WORD_SIZE-1:0] rdata1_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic                 mem_we_o,
  output logic                 mem_re_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic [WORD_SIZE-1:0] mem_rdata_i
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  localparam logic [WORD_SIZE-1:0] MEM_LIMIT = WORD_SIZE'(MEM_SIZE);

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 lat_we_q, lat_we_d;
  logic [WORD_SIZE-1:0] lat_addr_q, lat_addr_d;
  logic [WORD_SIZE-1:0] lat_wdata_q, lat_wdata_d;
  logic                 bad_q, bad_d;
  logic                 last_q, last_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] rdata0_q, rdata0_d;
  logic [WORD_SIZE-1:0] rdata1_q, rdata1_d;

  // A port in its own ack cycle is not eligible. This stops a port whose req
  // is still high from being granted again on the completion it just got.
  logic                 elig0, elig1, gnt;
  logic                 g_we;
  logic [WORD_SIZE-1:0] g_addr, g_wdata;

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise a latch is inferred.
    state_d     = state_q;
    sel_d       = sel_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    bad_d       = bad_q;
    last_d      = last_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    elig0   = req0_i & ~ack0_q;
    elig1   = req1_i & ~ack1_q;
    // On a tie the port that was not granted last wins; otherwise the only
    // eligible port wins.
    gnt     = (elig0 & elig1) ? ~last_q : elig1;
    g_we    = gnt ? we1_i    : we0_i;
    g_addr  = gnt ? addr1_i  : addr0_i;
    g_wdata = gnt ? wdata1_i : wdata0_i;

    unique case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          state_d     = SERVE;
          sel_d       = gnt;
          last_d      = gnt;
          lat_we_d    = g_we;
          lat_addr_d  = g_addr;
          lat_wdata_d = g_wdata;
          bad_d       = (g_addr[1:0] != 2'b00) || (g_addr >= MEM_LIMIT);
        end
      end
      SERVE: begin
        state_d = IDLE;
        err_d   = bad_q;
        if (sel_q) ack1_d = 1'b1;
        else       ack0_d = 1'b1;
        if (!lat_we_q) begin
          if (sel_q) rdata1_d = bad_q ? '0 : mem_rdata_i;
          else       rdata0_d = bad_q ? '0 : mem_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      bad_q       <= 1'b0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      bad_q       <= bad_d;
      last_q      <= last_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Memory controls are decoded from state, so a reset during SERVE drops
  // mem_we at once and the aborted write never commits.
  logic serving;
  assign serving     = (state_q == SERVE);
  assign busy_o      = serving;
  assign mem_we_o    = serving & lat_we_q & ~bad_q;
  assign mem_re_o    = serving & ~lat_we_q;
  assign mem_addr_o  = serving ? {lat_addr_q[WORD_SIZE-1:2], 2'b00} : '0;
  assign mem_wdata_o = serving ? lat_wdata_q : '0;

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign err_o    = err_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
  assign stall0_o = req0_i & ~ack0_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported byte-addressed data memory. It shares that memory between the pipeline MEM stage (port 0) and a secondary master such as a program/data loader or debug port (port 1). It uses a request/acknowledge handshake with round-robin fairness. It drives the memory's write enable, read enable, address and write data, captures the read data into a per-port register, and produces a stall for the pipeline while port 0 waits.

## Interface
- WORD_SIZE, 32: data and address width in bits.
- MEM_SIZE, 1024: memory size in bytes. Addresses at or above MEM_SIZE are out of range.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  WORD_SIZE  port 0 byte address.
- wdata0  in  WORD_SIZE  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  WORD_SIZE  port 0 read data, valid while ack0 is high and held until the next port-0 read completes.
- stall0  out  1  pipeline stall, equal to req0 & ~ack0 (combinational).
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- err  out  1  pulses with ack for a misaligned or out-of-range request.
- busy  out  1  high while in SERVE.
- mem_we  out  1  to memory writeEn.
- mem_re  out  1  to memory readEn.
- mem_addr  out  WORD_SIZE  to memory address.
- mem_wdata  out  WORD_SIZE  to memory dataIn.
- mem_rdata  in  WORD_SIZE  from memory dataOut (combinational read).

## Operation
- States: IDLE and SERVE. Registers: sel (granted port), lat_we, lat_addr, lat_wdata, bad, and last (round-robin pointer).
- Eligibility in IDLE: a port is eligible when req is high and its ack is low in the current cycle. This prevents re-granting a port whose request is still high during its own ack cycle.
- Grant in IDLE:
  - Only one port eligible: grant it.
  - Both eligible: grant the port ≠ last.
  - Reset value of last is 1, so port 0 wins the first tie.
  - On grant: latch we, addr and wdata of the granted port; set sel; set last = sel; go to SERVE.
  - No port eligible: stay in IDLE.
- In SERVE, the memory signals are driven from the latches:
  - mem_addr = lat_addr with bits [1:0] forced to 0.
  - mem_wdata = lat_wdata.
  - mem_we = lat_we & ~bad.
  - mem_re = ~lat_we.
- In IDLE, all mem_* outputs are 0.
- bad is set at grant when addr[1:0] ≠ 0 or addr ≥ MEM_SIZE. A bad write is suppressed (mem_we stays 0). A bad read returns 0 on rdata.
- Leaving SERVE (end of the SERVE cycle):
  - Go to IDLE.
  - Pulse ack for sel for one cycle.
  - For reads: rdata_sel ← mem_rdata, or 0 if bad. The other port's rdata is unchanged.
  - err ← bad for one cycle, aligned with the ack.
- Write commit: the memory commits the write on the same edge that ends SERVE.
- Requester rules:
  - addr, we and wdata must be stable from req assertion until ack.
  - req may drop in the ack cycle or remain high to request again.
  - If req remains high it is eligible from the cycle after ack.
- Reset (also mid-transaction): state, sel, latches, bad, ack0, ack1, err, rdata0 and rdata1 all go to 0; last goes to 1. Everything goes to IDLE immediately. An in-flight write is aborted: mem_we falls asynchronously, so there is no commit.

## Timing
- Reset values:
  - ack0 = 0, ack1 = 0, err = 0, busy = 0.
  - rdata0 = 0, rdata1 = 0.
  - mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0.
  - stall0 = req0.
- Single request latency: req high in cycle N (IDLE) → SERVE in N+1 → ack in N+2.
- Stall: stall0 is high for cycles N and N+1, low in N+2.
- Back-to-back alternating ports: one transaction every 2 cycles.
- Same port requesting repeatedly with no contention: one transaction every 3 cycles. The ack-cycle ineligibility costs one extra cycle.
- Simultaneous requests: served 0,1,0,1,… when both are held continuously. Neither port waits more than one transaction of the other.
- A request arriving during SERVE is considered in the next IDLE cycle.

## Test plan
- Port 0 write of 0xDEADBEEF to address 0x10, then a port 0 read of 0x10:
  - Write: ack0 two cycles after req0; mem_we is high for exactly one cycle.
  - Read: rdata0 = 0xDEADBEEF with ack0; stall0 high for 2 cycles per access.
- req0 and req1 both asserted from reset and held for 4 transactions:
  - Grant order is 0,1,0,1.
  - Acks alternate every 2 cycles; ack0 and ack1 are never high together.
- Port 1 read of 0x20 while port 0 is idle:
  - rdata1 updated, rdata0 unchanged, stall0 = 0 throughout.
- Port 0 write to 0x13 (misaligned), then a port 0 read of 0x400 (out of range, MEM_SIZE = 1024):
  - The write gives ack0 with err = 1 and mem_we is never high; the memory word at 0x10 is unchanged.
  - The read gives rdata0 = 0 with err = 1.
- rst asserted mid-SERVE of a port 1 write of 0x12345678 to 0x40:
  - mem_we drops immediately; no ack1.
  - A later read of 0x40 returns its prior value.
  - After reset, the first tie goes to port 0.
- Port 0 holds req0 high for 3 consecutive reads of 0x0, 0x4, 0x8, changing addr after each ack:
  - ack0 occurs every 3 cycles; rdata0 returns the correct word for each read.
